// File: rtl/seq_det_pkg.sv
// Shared constants, types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

    localparam logic [7:0] DEFAULT_PATTERN_INIT = 8'b0000_1011;
    localparam int         DEFAULT_LEN_INIT     = 4;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } det_mode_e;

    // Width needed to hold a length value of 0..max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Zero and out-of-range lengths both mean "use the full history".
    function automatic int clamp_len(input int raw, input int max_len);
        if (raw == 0 || raw > max_len) return max_len;
        return raw;
    endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter; a synchronous clear takes priority over an increment.
module seq_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector: runtime-loadable pattern of 1..MAX_LEN bits,
// overlapping or non-overlapping detection, registered match pulse and saturating count.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int                   MAX_LEN         = 8,
    parameter int                   CNT_W           = 8,
    parameter logic [MAX_LEN-1:0]   DEFAULT_PATTERN = MAX_LEN'(DEFAULT_PATTERN_INIT),
    parameter int                   DEFAULT_LEN     = DEFAULT_LEN_INIT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         w,
    input  logic                         in_valid,
    input  logic                         cfg_load,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [len_w(MAX_LEN)-1:0]    cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         cnt_clr,
    output logic                         z,
    output logic [CNT_W-1:0]             match_count
);

    localparam int                LEN_W    = len_w(MAX_LEN);
    localparam logic [LEN_W-1:0]  FILL_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    det_mode_e          mode;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W:0]     fill_plus;
    logic [LEN_W-1:0]   len_load;
    logic               hit;

    // window is the history as it would look with the current bit shifted in.
    always_comb begin
        window    = {hist[MAX_LEN-2:0], w};
        len_load  = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
        fill_plus = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
        len_mask  = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len));
        end
        hit = in_valid && !cfg_load
              && (fill_plus >= {1'b0, len})
              && (((window ^ pattern) & len_mask) == '0);
    end

    // The configuration registers reset to the defaults so the block detects the
    // legacy fixed pattern without any software setup.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist    <= '0;
            fill    <= '0;
            z       <= 1'b0;
            pattern <= DEFAULT_PATTERN;
            len     <= LEN_W'(DEFAULT_LEN);
            mode    <= MODE_OVL;
        end else if (cfg_load) begin
            pattern <= cfg_pattern;
            len     <= len_load;
            mode    <= cfg_overlap ? MODE_OVL : MODE_NONOVL;
            hist    <= '0;
            fill    <= '0;
            z       <= 1'b0;
        end else if (in_valid) begin
            hist <= window;
            z    <= hit;
            if (hit && (mode == MODE_NONOVL)) begin
                fill <= '0;
            end else if (fill != FILL_MAX) begin
                fill <= fill_plus[LEN_W-1:0];
            end
        end else begin
            z <= 1'b0;
        end
    end

    seq_sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (hit),
        .clr   (cnt_clr),
        .count (match_count)
    );

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed self-checking bench for seq_detector_prog, including a 2-bit-counter
// instance that exercises match_count saturation.
module tb_seq_detector_prog;

    logic       clk = 1'b0;
    logic       reset;
    logic       w;
    logic       in_valid;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       cnt_clr;
    logic       z;
    logic [7:0] match_count;
    logic       z_sat;
    logic [1:0] match_count_sat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detector_prog dut (
        .clk         (clk),
        .reset       (reset),
        .w           (w),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .z           (z),
        .match_count (match_count)
    );

    seq_detector_prog #(.CNT_W(2)) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .w           (w),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .z           (z_sat),
        .match_count (match_count_sat)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock with the given inputs; returns #1 after the edge that sampled them.
    task automatic tick(input logic wb, input logic v);
        w        = wb;
        in_valid = v;
        @(posedge clk);
        #1;
        w        = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic bit_step(input logic wb, input logic exp_z, input string tag);
        tick(wb, 1'b1);
        check(tag, 32'(z), 32'(exp_z));
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] ln, input logic ovl,
                        input logic wb, input logic v);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = ln;
        cfg_overlap = ovl;
        tick(wb, v);
        cfg_load = 1'b0;
        check("z_after_load", 32'(z), 32'd0);
    endtask

    initial begin
        logic [6:0] s7;
        logic [6:0] z7;
        logic [7:0] s8;
        logic [1:0] sat_exp [6];

        reset = 1'b0; w = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
        cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check("reset_z", 32'(z), 32'd0);
        check("reset_count", 32'(match_count), 32'd0);

        // 1: default pattern 1011, overlapping.
        s7 = 7'b1011011;
        z7 = 7'b0001001;
        for (int i = 6; i >= 0; i--) bit_step(s7[i], z7[i], "t1_ovl_z");
        check("t1_count", 32'(match_count), 32'd2);

        // 2: non-overlapping; count survives cfg_load.
        load(8'b0000_1011, 4'd4, 1'b0, 1'b0, 1'b0);
        z7 = 7'b0001000;
        for (int i = 6; i >= 0; i--) bit_step(s7[i], z7[i], "t2_nonovl_z");
        check("t2_count", 32'(match_count), 32'd3);

        // 3a: gaps between valid bits are transparent.
        load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            bit_step(s7[i + 3], (i == 0), "t3_gap_bit_z");
            for (int g = 0; g < 3; g++) begin
                tick(1'b0, 1'b0);
                check("t3_gap_idle_z", 32'(z), 32'd0);
            end
        end
        check("t3_gap_count", 32'(match_count), 32'd4);

        // 3b: a valid bit coinciding with cfg_load is discarded.
        load(8'b0000_1011, 4'd4, 1'b1, 1'b1, 1'b1);
        bit_step(1'b0, 1'b0, "t3_discard_z0");
        bit_step(1'b1, 1'b0, "t3_discard_z1");
        bit_step(1'b1, 1'b0, "t3_discard_z2");
        check("t3_discard_count", 32'(match_count), 32'd4);

        // 4a: cfg_len 0 and cfg_len > MAX_LEN both clamp to 8.
        s8 = 8'hA5;
        load(8'hA5, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) bit_step(s8[i], (i == 0), "t4_len0_z");
        load(8'hA5, 4'd15, 1'b1, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) bit_step(s8[i], (i == 0), "t4_len15_z");
        check("t4_len_count", 32'(match_count), 32'd6);

        // 4b: len 1 matches every bit equal to pattern[0].
        load(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
        bit_step(1'b1, 1'b1, "t4_len1_z0");
        bit_step(1'b1, 1'b1, "t4_len1_z1");
        bit_step(1'b0, 1'b0, "t4_len1_z2");
        bit_step(1'b1, 1'b1, "t4_len1_z3");
        check("t4_len1_count", 32'(match_count), 32'd9);

        // 5: saturation on the 2-bit counter instance, then clear beats a match.
        cnt_clr = 1'b1;
        tick(1'b0, 1'b0);
        cnt_clr = 1'b0;
        check("t5_clr_count", 32'(match_count), 32'd0);
        check("t5_clr_count_sat", 32'(match_count_sat), 32'd0);
        load(8'b0000_0011, 4'd2, 1'b1, 1'b0, 1'b0);
        sat_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b1);
            check("t5_sat_z", 32'(z_sat), 32'(i != 0));
            check("t5_sat_count", 32'(match_count_sat), 32'(sat_exp[i]));
        end
        cnt_clr = 1'b1;
        tick(1'b1, 1'b1);
        cnt_clr = 1'b0;
        check("t5_clr_match_z", 32'(z_sat), 32'd1);
        check("t5_clr_match_count_sat", 32'(match_count_sat), 32'd0);
        check("t5_clr_match_count", 32'(match_count), 32'd0);

        // 6: reset mid-pattern must not complete the pattern afterwards.
        load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
        bit_step(1'b1, 1'b0, "t6_pre_z0");
        bit_step(1'b0, 1'b0, "t6_pre_z1");
        bit_step(1'b1, 1'b0, "t6_pre_z2");
        bit_step(1'b1, 1'b1, "t6_pre_z3");
        bit_step(1'b1, 1'b0, "t6_pre_z4");
        bit_step(1'b0, 1'b0, "t6_pre_z5");
        bit_step(1'b1, 1'b0, "t6_pre_z6");
        check("t6_pre_count", 32'(match_count), 32'd1);
        reset = 1'b0;
        #1;
        check("t6_async_z", 32'(z), 32'd0);
        check("t6_async_count", 32'(match_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bit_step(1'b1, 1'b0, "t6_post_z0");
        bit_step(1'b0, 1'b0, "t6_post_z1");
        bit_step(1'b1, 1'b0, "t6_post_z2");
        bit_step(1'b1, 1'b1, "t6_post_z3");
        check("t6_post_count", 32'(match_count), 32'd1);
        tick(1'b0, 1'b0);
        check("t6_pulse_width", 32'(z), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
Programmable serial pattern detector, successor to the fixed-pattern sequence detector. Detects a runtime-loadable bit pattern of length 1..MAX_LEN on serial input w. Overlapping or non-overlapping detection is selectable. Produces a registered match pulse z and a saturating match counter. Sits on the serial-input side of the datapath wherever the single-pattern detector is used today.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of match_count
DEFAULT_PATTERN, 8'b0000_1011, pattern after reset (LSB-aligned, bit len-1 is the first bit received)
DEFAULT_LEN, 4, pattern length after reset

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
w  in  1  serial data bit
in_valid  in  1  w is sampled only when 1
cfg_load  in  1  load pattern/length/mode and clear detection history
cfg_pattern  in  MAX_LEN  pattern; bit len-1 is the oldest bit, bit 0 the newest
cfg_len  in  $clog2(MAX_LEN+1)  pattern length
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
cnt_clr  in  1  synchronous clear of match_count
z  out  1  one-cycle match pulse, registered
match_count  out  CNT_W  number of matches, saturating

Behaviour:
- Reset (reset=0, asynchronous):
  - hist=0, fill=0, z=0, match_count=0.
  - Pattern register = DEFAULT_PATTERN, len = DEFAULT_LEN, overlap = 1.
- History and fill:
  - hist is a MAX_LEN-bit shift register; on in_valid, hist <= {hist[MAX_LEN-2:0], w}.
  - fill counts valid bits since the last clear and saturates at MAX_LEN.
- Match condition, evaluated when in_valid=1:
  - (fill >= len-1) and ({hist, w} low len bits == pattern low len bits).
- Latency: z=1 in the cycle after the rising edge that sampled the completing bit. z lasts exactly one cycle per match; otherwise z=0.
- Gaps: in_valid=0 cycles are transparent. History, fill and matches are unaffected, and z is 0 in those cycles unless set by the previous sample.
- Overlap mode: after a match, history and fill are retained, so the suffix can start the next match. Example: pattern 1011 on stream 1011011 gives 2 matches.
- Non-overlap mode: after a match, fill <= 0. The next match needs len fresh bits. The same stream gives 1 match.
- cfg_len handling:
  - cfg_len=0 or cfg_len>MAX_LEN is clamped to MAX_LEN.
  - len=1 is legal; every valid bit equal to pattern[0] matches.
- cfg_load:
  - On the clock edge, latches pattern, clamped len and overlap.
  - Clears hist, fill and z. match_count is not cleared.
  - A w sample with in_valid in the same cycle is discarded.
  - cfg_load has priority over in_valid.
- match_count:
  - Increments by 1 on each match (registered with z) and saturates at all-ones.
  - cnt_clr zeroes it. If cnt_clr and a match coincide, the result is 0 (clear wins).
- Reset mid-stream: all state returns to reset values immediately. A partially received pattern is never completed across reset.
- No output depends combinationally on inputs.

Decomposition:
- Package seq_det_pkg holds:
  - LEN_W localparam function, the clamp_len function, and the DEFAULT_* constants.
  - typedef det_mode_e {MODE_NONOVL=0, MODE_OVL=1}.
- One sub-module: seq_sat_counter (CNT_W parameter; inc, clr, count; clear-over-increment priority; saturating). It is reused for match_count.
- Compare/shift logic stays in the top module.

Test Plan:
1. Reset defaults: pattern 1011, len 4, overlap; in_valid=1, stream 1,0,1,1,0,1,1 -> z pulses one cycle after the 4th and 7th bits; match_count=2.
2. Non-overlap: cfg_load pattern 1011, len 4, overlap 0; same stream -> single z after the 4th bit; match_count=3 (count not cleared by cfg_load).
3. Gaps plus cfg_load discard:
   - Stream 1,0,1,1 with in_valid=0 for 3 cycles between each bit -> z one cycle after the last valid bit only.
   - cfg_load asserted together with a valid bit -> that bit is ignored and no spurious match occurs.
4. Length edge cases:
   - cfg_len=0 with cfg_pattern=8'hA5 -> len 8; stream 1010_0101 -> z after the 8th bit only.
   - cfg_len=1, pattern[0]=1, stream 1,1,0,1 -> z after bits 1, 2 and 4.
5. Saturation: CNT_W=2, pattern 11, len 2, overlap; stream of 6 ones -> match_count 1,2,3,3,3. Then cnt_clr together with a match -> match_count=0.
6. Reset mid-pattern: after bits 1,0,1 of 1011, pull reset low for 1 cycle, then feed 1 -> no z; match_count=0. Then feed 0,1,1 -> still no z until a full 1,0,1,1 is received after reset.
